// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM states, word width and operation encoding for mem_responder
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with synchronous write port and registered read port, no reset
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency single-port memory responder (IDLE/WAIT/RESP FSM)
// Optional: MEM_MISALIGN_CHECK_EN flags addr[1:0]!=0 with mem_err and suppresses the access.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    op_t               op_q;
    logic              err_q;
    logic              rd_seen;
    logic [WORD_W-1:0] array_q;
    logic              accept;
    logic              commit;
    logic              req_err;
    logic              arr_we;
    logic              arr_re;

    // High address bits wrap; they only feed this reduction so they stay visible.
    logic unused_addr;
    assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

    assign accept = (state == IDLE) && (ctrl_mem_read || ctrl_mem_write);
    assign commit = (state == WAIT) && (cnt == 4'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    assign req_err = (addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write wins when both request lines are high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            err_q   <= 1'b0;
            rd_seen <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= 4'(LATENCY);
                idx_q   <= addr[IDX_W+1:2];
                wdata_q <= write_data;
                op_q    <= ctrl_mem_write ? OP_WRITE : OP_READ;
                err_q   <= req_err;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (arr_re) begin
                rd_seen <= 1'b1;
            end
        end
    end

    assign arr_we = commit && (op_q == OP_WRITE) && !err_q;
    assign arr_re = commit && (op_q == OP_READ) && !err_q;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (array_q)
    );

    // The array read register has no reset, so read_data is masked until a read lands.
    assign read_data = rd_seen ? array_q : '0;
    assign mem_ready = (state == RESP);
    assign mem_busy  = (state != IDLE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign mem_err = mem_ready && err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ctrl_mem_read  input  1  read request, sampled only in IDLE.
REQ-006 ctrl_mem_write  input  1  write request, sampled only in IDLE.
REQ-007 addr  input  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-008 write_data  input  32  store data, sampled with the request.
REQ-009 read_data  output  32  load data, valid while mem_ready=1, held until the next read completes.
REQ-010 mem_ready  output  1  one-cycle response pulse.
REQ-011 mem_busy  output  1  high in WAIT and RESP.
REQ-012 mem_err  output  1  misalignment error, qualified by mem_ready.

Function
REQ-013 FSM states IDLE, WAIT, RESP; IDLE->WAIT on accepted request; WAIT->RESP when wait counter is 0; RESP->IDLE unconditionally.
REQ-014 On acceptance, addr, write_data and operation are latched and the counter is loaded with LATENCY; in WAIT the counter decrements by 1 per cycle.
REQ-015 With LATENCY=0, WAIT lasts one cycle; mem_ready rises LATENCY+1 cycles after the accepting edge.
REQ-016 The write commits to the array on the WAIT->RESP edge; read_data loads from the array on the same edge.
REQ-017 Both ctrl_mem_read and ctrl_mem_write high in IDLE: write performed, read ignored, read_data unchanged.
REQ-018 Requests are ignored outside IDLE; deasserting a request mid-operation does not abort it.
REQ-019 A request still high in the cycle after RESP (IDLE) is accepted as a new request; no back-to-back acceptance without one IDLE cycle.
REQ-020 Address bits above the word index are ignored (wrap-around modulo DEPTH_WORDS).
REQ-021 A write response keeps read_data unchanged; mem_err=0 on every response when the check is compiled out.

Reset
REQ-022 rst_n low forces state IDLE, counter 0, read_data 0, mem_ready 0, mem_busy 0, mem_err 0.
REQ-023 Reset during WAIT aborts the operation; an uncommitted write does not reach the array.
REQ-024 Array contents are not reset.

Configuration
REQ-025 With MEM_MISALIGN_CHECK_EN defined, addr[1:0]!=0 on acceptance yields no array access, same latency, mem_ready=1 with mem_err=1, read_data unchanged.
REQ-026 Without MEM_MISALIGN_CHECK_EN, addr[1:0] are ignored and mem_err is tied 0.

Structure
REQ-027 Shared package mem_pkg holds the state enum (IDLE, WAIT, RESP), word width constant 32 and the op encoding (OP_READ, OP_WRITE).
REQ-028 Storage is a sub-module mem_array (synchronous write port, registered read port, no reset); FSM and latches live in mem_responder.

Verification
REQ-029 Write 1337 to addr 20, then read addr 20, LATENCY=2 -> mem_ready 3 cycles after each accept, read_data=1337.
REQ-030 Read addr 20+4*256 after REQ-029 -> read_data=1337 (wrap).
REQ-031 Both ctrl lines high, addr 8, write_data 15 -> later read of addr 8 returns 15; read_data unchanged at that response.
REQ-032 Write 10 to addr 12, rst_n low for 1 cycle in WAIT -> outputs 0, later read of addr 12 returns the prior value.
REQ-033 With MEM_MISALIGN_CHECK_EN, write 99 to addr 21 -> mem_ready with mem_err=1, read of addr 20 still 1337; without the macro, read of addr 20 returns 99.
REQ-034 Request held high across RESP -> second acceptance exactly one IDLE cycle later; mem_busy low only that cycle.
